serial_add_scheduler: RTL and testbench

- Round-robin scheduler that shares one bit-serial adder datapath between NREQ requesters.
- Each requester offers parallel operands plus carry-in over a valid/ready handshake.
- The block latches the granted operands, adds them LSB-first over WIDTH cycles, and returns sum, carry-out and requester id over a valid/ready response port.
- Sits between the parallel-operand clients and the serial-adder resource; it is the sole owner of that datapath.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_rr_arbiter.sv | 33 +++
 rtl/serial_add_scheduler.sv | 109 ++++++++++
 tb/tb_serial_add_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the round-robin serial-add scheduler.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_WIDTH = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_add_rr_arbiter.sv
// Combinational round-robin pick: first requester above 'last', wrapping to the lowest.
module serial_add_rr_arbiter
    import serial_add_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] sel;

    // Requesters above the pointer win; if none of them is asking, wrap to the full set.
    always_comb begin
        hi  = '0;
        gnt = '0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) hi[i] = (IDW'(i) > last);
        masked = req & hi;
        sel    = (|masked) ? masked : req;
        for (int i = NREQ - 1; i >= 0; i--) if (sel[i]) idx = IDW'(i);
        for (int i = 0; i < NREQ; i++) gnt[i] = sel[i] && (IDW'(i) == idx);
    end

    assign any = |req;

endmodule

// File: rtl/serial_add_scheduler.sv
// Shares one LSB-first bit-serial adder among NREQ requesters with round-robin arbitration.
module serial_add_scheduler
    import serial_add_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*WIDTH-1:0]       req_a,
    input  logic [NREQ*WIDTH-1:0]       req_b,
    input  logic [NREQ-1:0]             req_cin,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [IDW-1:0]              resp_id,
    output logic [WIDTH-1:0]            resp_sum,
    output logic                        resp_cout,
    output logic                        busy,
    output logic [clog2(WIDTH+1)-1:0]   bit_count
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             c, cout, cin_sel, sbit, maj;
    logic [IDW-1:0]   id, last_grant, gidx;
    logic [NREQ-1:0]  gnt;
    logic             any;

    serial_add_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req  (req_valid),
        .last (last_grant),
        .gnt  (gnt),
        .idx  (gidx),
        .any  (any)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
        cin_sel = |(req_cin & gnt);
        sbit    = a_sh[0] ^ b_sh[0] ^ c;
        maj     = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        sum_nx  = sum_sh >> 1;
        sum_nx[WIDTH-1] = sbit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            c          <= 1'b0;
            cout       <= 1'b0;
            id         <= '0;
            last_grant <= IDW'(NREQ - 1);
            bit_count  <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    a_sh       <= a_sel;
                    b_sh       <= b_sel;
                    c          <= cin_sel;
                    id         <= gidx;
                    last_grant <= gidx;
                    bit_count  <= '0;
                    state      <= ADD;
                end
                ADD: begin
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    sum_sh    <= sum_nx;
                    c         <= maj;
                    bit_count <= bit_count + 1'b1;
                    if (bit_count == CW'(WIDTH - 1)) begin
                        cout  <= maj;
                        state <= DONE;
                    end
                end
                DONE: if (resp_ready) begin
                    bit_count <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so no requester sees an acceptance strobe while held in reset.
    assign req_ready  = (rst && state == IDLE) ? gnt : '0;
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign resp_sum   = sum_sh;
    assign resp_cout  = cout;
    assign resp_id    = id;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Scoreboard bench for serial_add_scheduler with NREQ=2, WIDTH=4.
module tb_serial_add_scheduler;

    localparam int NREQ = 2;
    localparam int W    = 4;
    localparam int IDW  = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, req_cin;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic                resp_valid, resp_ready, resp_cout, busy;
    logic [IDW-1:0]      resp_id;
    logic [W-1:0]        resp_sum;
    logic [2:0]          bit_count;

    serial_add_scheduler #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    typedef struct {int id; int sum; int cout;} exp_t;
    exp_t q[$];
    exp_t me;
    int   n_cmp = 0, n_err = 0, cyc = 0, gcyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst === 1'b1 && resp_valid && resp_ready) begin
            if (q.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
                me = q.pop_front();
                chk("resp_id",   int'(resp_id),   me.id);
                chk("resp_sum",  int'(resp_sum),  me.sum);
                chk("resp_cout", int'(resp_cout), me.cout);
            end
        end
    end

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_cin[r]      = ci;
        req_valid[r]    = 1'b1;
    endtask

    task automatic grant_push(input int r, input bit push, input int es, input int ec);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (req_ready != '0) ok = 1'b1;
        end
        if (!ok) chk("grant_timeout", 0, 1);
        else begin
            chk("grant", int'(req_ready), 1 << r);
            chk("grant_bitcnt", int'(bit_count), 0);
            gcyc = cyc;
            if (push) q.push_back('{r, es, ec});
        end
    endtask

    task automatic do_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int es, input int ec);
        set_req(r, a, b, ci);
        grant_push(r, 1'b1, es, ec);
        @(posedge clk); #1 req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !resp_valid) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        rst = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_cin = '0; resp_ready = 1'b1;
        #2;
        chk("rst_valid",  int'(resp_valid), 0);
        chk("rst_ready",  int'(req_ready),  0);
        chk("rst_busy",   int'(busy),       0);
        chk("rst_bitcnt", int'(bit_count),  0);
        chk("rst_sum",    int'(resp_sum),   0);
        chk("rst_cout",   int'(resp_cout),  0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single op with bit_count / busy / latency trace
        set_req(0, 4'b0101, 4'b0011, 1'b0);
        grant_push(0, 1'b1, 4'b1000, 0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("trace_bitcnt", int'(bit_count), i);
            chk("trace_busy",   int'(busy), 1);
            chk("trace_valid",  int'(resp_valid), (i == 4) ? 1 : 0);
        end
        wait_idle();

        // Carry cases
        do_op(0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1); wait_idle();
        do_op(0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1); wait_idle();
        do_op(1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 0); wait_idle();

        // Contention: 3+4=7, 8+9+1=18 -> 0010 carry 1
        set_req(0, 4'b0011, 4'b0100, 1'b0);
        set_req(1, 4'b1000, 4'b1001, 1'b1);
        for (int n = 0; n < 4; n++) begin
            prev = gcyc;
            grant_push(n % 2, 1'b1, (n % 2) ? 4'b0010 : 4'b0111, n % 2);
            if (n > 0) chk("spacing", gcyc - prev, 6);
        end
        @(posedge clk); #1 req_valid = '0;
        wait_idle();

        // Backpressure: 6+7=13, req1 waits meanwhile
        resp_ready = 1'b0;
        set_req(1, 4'b0001, 4'b0001, 1'b0);
        do_op(0, 4'b0110, 4'b0111, 1'b0, 4'b1101, 0);
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(resp_valid), 1);
            chk("bp_sum",   int'(resp_sum),   4'b1101);
            chk("bp_id",    int'(resp_id),    0);
            chk("bp_ready", int'(req_ready),  0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        grant_push(1, 1'b1, 4'b0010, 0);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_idle();

        // Reset mid-ADD with req1 waiting; req0 must still win first after release
        set_req(0, 4'b1111, 4'b0000, 1'b0);
        set_req(1, 4'b0111, 4'b0101, 1'b1);
        grant_push(0, 1'b0, 0, 0);
        for (int i = 0; i < 20 && bit_count != 3'd2; i++) @(negedge clk);
        chk("mid_bitcnt", int'(bit_count), 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_sum",    int'(resp_sum),   0);
        chk("arst_bitcnt", int'(bit_count),  0);
        chk("arst_busy",   int'(busy),       0);
        chk("arst_ready",  int'(req_ready),  0);
        chk("arst_valid",  int'(resp_valid), 0);
        chk("arst_cout",   int'(resp_cout),  0);
        @(posedge clk); #1 rst = 1'b1;
        grant_push(0, 1'b1, 4'b1111, 0);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        grant_push(1, 1'b1, 4'b1101, 0);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_idle();

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
